// File: rtl/contador_pkg.sv
// Shared constants for the multi-digit BCD counter and its display decoder.
// Segment constants are active-high, ordered {a,b,c,d,e,f,g}.
package contador_pkg;

   localparam logic [3:0] BCD_MAX = 4'd9;

   localparam logic [6:0] SEG_0 = 7'b1111110;
   localparam logic [6:0] SEG_1 = 7'b0110000;
   localparam logic [6:0] SEG_2 = 7'b1101101;
   localparam logic [6:0] SEG_3 = 7'b1111001;
   localparam logic [6:0] SEG_4 = 7'b0110011;
   localparam logic [6:0] SEG_5 = 7'b1011011;
   localparam logic [6:0] SEG_6 = 7'b1011111;
   localparam logic [6:0] SEG_7 = 7'b1110000;
   localparam logic [6:0] SEG_8 = 7'b1111111;
   localparam logic [6:0] SEG_9 = 7'b1111011;

   // Counter width for a divider of n states; never below one bit.
   function automatic int largura(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/decodificador_bcd_7seg.sv
// Combinational BCD digit to active-high a..g segment pattern.
// Polarity for the board is applied by the parent.
module decodificador_bcd_7seg
   import contador_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_0;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_0;
      endcase
   end

endmodule

// File: rtl/contador_automatico_bcd_multidigito.sv
// Free-running multi-digit BCD up/down counter with prescaler, load,
// wrap flag and a time-multiplexed 7-segment display driver.
module contador_automatico_bcd_multidigito
   import contador_pkg::*;
#(
   parameter int DIGITOS         = 4,
   parameter int DIV_CONTAGEM    = 25_000_000,
   parameter int DIV_VARREDURA   = 50_000,
   parameter int SEG_ATIVO_BAIXO = 1
)(
   input  logic                   clock_inicial,
   input  logic                   reset,
   input  logic                   habilita,
   input  logic                   sentido,
   input  logic                   carga,
   input  logic [4*DIGITOS-1:0]   valor_carga,
   output logic [4*DIGITOS-1:0]   S,
   output logic                   tick,
   output logic                   estouro,
   output logic [DIGITOS-1:0]     seletor,
   output logic                   a,
   output logic                   b,
   output logic                   c,
   output logic                   d,
   output logic                   e,
   output logic                   f,
   output logic                   g
);

   localparam int WP = largura(DIV_CONTAGEM);
   localparam int WV = largura(DIV_VARREDURA);
   localparam int WI = largura(DIGITOS);

   localparam logic [WP-1:0] PRE_FIM = WP'(DIV_CONTAGEM - 1);
   localparam logic [WV-1:0] VAR_FIM = WV'(DIV_VARREDURA - 1);
   localparam logic [WI-1:0] IDX_FIM = WI'(DIGITOS - 1);
   localparam logic          POL_BX  = (SEG_ATIVO_BAIXO != 0);

   localparam logic [DIGITOS-1:0] SEL_0 = DIGITOS'(1);

   logic [WP-1:0]          pre;
   logic [WV-1:0]          varre;
   logic [WI-1:0]          idx;
   logic                   fim_pre;
   logic                   fim_var;
   logic [4*DIGITOS-1:0]   s_prox;
   logic [4*DIGITOS-1:0]   carga_lim;
   logic                   vai;
   logic [3:0]             dig;
   logic [3:0]             dig_sel;
   logic [DIGITOS-1:0]     sel_quente;
   logic [6:0]             seg_dec;
   logic [6:0]             seg_r;
   logic [DIGITOS-1:0]     sel_r;

   assign fim_pre = (pre == PRE_FIM);
   assign fim_var = (varre == VAR_FIM);

   // Load and reset both suppress the step, so the pulse is gated here.
   assign tick = !reset && habilita && !carga && fim_pre;

   // Ripple carry/borrow through the digit chain; vai left set means wrap.
   always_comb begin
      s_prox = S;
      vai    = 1'b1;
      dig    = 4'd0;
      for (int i = 0; i < DIGITOS; i++) begin
         dig = S[4*i +: 4];
         if (vai) begin
            if (sentido) begin
               if (dig == BCD_MAX) begin
                  s_prox[4*i +: 4] = 4'd0;
               end else begin
                  s_prox[4*i +: 4] = dig + 4'd1;
                  vai = 1'b0;
               end
            end else begin
               if (dig == 4'd0) begin
                  s_prox[4*i +: 4] = BCD_MAX;
               end else begin
                  s_prox[4*i +: 4] = dig - 4'd1;
                  vai = 1'b0;
               end
            end
         end
      end
   end

   always_comb begin
      carga_lim = valor_carga;
      for (int i = 0; i < DIGITOS; i++) begin
         if (valor_carga[4*i +: 4] > BCD_MAX) begin
            carga_lim[4*i +: 4] = BCD_MAX;
         end
      end
   end

   always_ff @(posedge clock_inicial) begin
      if (reset) begin
         S       <= '0;
         pre     <= '0;
         estouro <= 1'b0;
      end else if (carga) begin
         S       <= carga_lim;
         pre     <= '0;
         estouro <= 1'b0;
      end else begin
         estouro <= tick && vai;
         if (habilita) begin
            pre <= fim_pre ? '0 : pre + WP'(1);
         end
         if (tick) begin
            S <= s_prox;
         end
      end
   end

   always_comb begin
      dig_sel    = 4'd0;
      sel_quente = '0;
      for (int i = 0; i < DIGITOS; i++) begin
         if (idx == WI'(i)) begin
            dig_sel       = S[4*i +: 4];
            sel_quente[i] = 1'b1;
         end
      end
   end

   decodificador_bcd_7seg u_dec (
      .bcd (dig_sel),
      .seg (seg_dec)
   );

   // Select and segments are registered together from one index value.
   always_ff @(posedge clock_inicial) begin
      if (reset) begin
         varre <= '0;
         idx   <= '0;
         sel_r <= POL_BX ? ~SEL_0 : SEL_0;
         seg_r <= POL_BX ? ~SEG_0 : SEG_0;
      end else begin
         varre <= fim_var ? '0 : varre + WV'(1);
         if (fim_var) begin
            idx <= (idx == IDX_FIM) ? '0 : idx + WI'(1);
         end
         sel_r <= POL_BX ? ~sel_quente : sel_quente;
         seg_r <= POL_BX ? ~seg_dec : seg_dec;
      end
   end

   assign seletor = sel_r;
   assign {a, b, c, d, e, f, g} = seg_r;

endmodule
